// File: rtl/pipe_scroller_if.sv
// Obstacle geometry bus between the game controller and the pipe scroller.
interface pipe_scroller_if;
    logic       tick;
    logic       start;
    logic       collide;
    logic [9:0] pipe_x;
    logic [9:0] gap_top;
    logic [9:0] gap_bot;
    logic       passed;
    logic [7:0] score;
    logic       running;

    modport master (
        output tick, start, collide,
        input  pipe_x, gap_top, gap_bot, passed, score, running
    );

    modport slave (
        input  tick, start, collide,
        output pipe_x, gap_top, gap_bot, passed, score, running
    );
endinterface

// File: rtl/pipe_scroller.sv
// Scrolls a single pipe leftward per frame tick, respawns it at the right
// edge with an LFSR-chosen gap, counts passes and freezes on collision.
module pipe_scroller #(
    parameter int unsigned    SCREEN_W  = 640,
    parameter int unsigned    PIPE_W    = 40,
    parameter int unsigned    BIRD_X    = 160,
    parameter int unsigned    SPEED     = 2,
    parameter int unsigned    GAP_MIN   = 60,
    parameter int unsigned    GAP_H     = 120,
    parameter logic [9:0]     LFSR_SEED = 10'h2A5
) (
    input  logic            clk,
    input  logic            reset,
    pipe_scroller_if.slave  bus
);

    localparam logic [9:0]  SCREEN_W_V = 10'(SCREEN_W);
    localparam logic [10:0] PIPE_W_V   = 11'(PIPE_W);
    localparam logic [10:0] BIRD_X_V   = 11'(BIRD_X);
    localparam logic [9:0]  SPEED_V    = 10'(SPEED);
    localparam logic [9:0]  GAP_MIN_V  = 10'(GAP_MIN);
    localparam logic [9:0]  GAP_H_V    = 10'(GAP_H);
    localparam logic [9:0]  TOP_RST    = 10'd180;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t      state_q;
    logic [9:0]  lfsr_q;
    logic [9:0]  pipe_x_q;
    logic [9:0]  gap_top_q;
    logic [9:0]  gap_bot_q;
    logic        passed_q;
    logic [7:0]  score_q;
    logic        running_q;

    logic [9:0]  lfsr_d;
    logic [9:0]  moved_x;
    logic [10:0] sum_before;
    logic [10:0] sum_after;
    logic        pass_hit;
    logic [9:0]  respawn_top;

    // Move arithmetic, pass test and LFSR feedback for the current state
    always_comb begin
        moved_x     = pipe_x_q - SPEED_V;
        sum_before  = {1'b0, pipe_x_q} + PIPE_W_V;
        sum_after   = {1'b0, moved_x} + PIPE_W_V;
        pass_hit    = (sum_before >= BIRD_X_V) && (sum_after < BIRD_X_V);
        respawn_top = GAP_MIN_V + {3'b000, lfsr_q[6:0]};
        lfsr_d      = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    end

    // Game FSM with registered geometry, score and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            pipe_x_q  <= SCREEN_W_V;
            gap_top_q <= TOP_RST;
            gap_bot_q <= TOP_RST + GAP_H_V;
            passed_q  <= 1'b0;
            score_q   <= '0;
            running_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            passed_q <= 1'b0;
            // start restarts from any state; from IDLE the values are
            // already at their reset values so this is the same transition.
            if (bus.start) begin
                state_q   <= SCROLL;
                pipe_x_q  <= SCREEN_W_V;
                gap_top_q <= TOP_RST;
                gap_bot_q <= TOP_RST + GAP_H_V;
                score_q   <= '0;
                running_q <= 1'b1;
            end else begin
                case (state_q)
                    SCROLL: begin
                        if (bus.collide) begin
                            state_q   <= FROZEN;
                            running_q <= 1'b0;
                        end else if (bus.tick) begin
                            if (pipe_x_q >= SPEED_V) begin
                                pipe_x_q <= moved_x;
                                if (pass_hit) begin
                                    passed_q <= 1'b1;
                                    if (score_q != 8'hFF) begin
                                        score_q <= score_q + 8'd1;
                                    end
                                end
                            end else begin
                                pipe_x_q  <= SCREEN_W_V;
                                gap_top_q <= respawn_top;
                                gap_bot_q <= respawn_top + GAP_H_V;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.pipe_x  = pipe_x_q;
    assign bus.gap_top = gap_top_q;
    assign bus.gap_bot = gap_bot_q;
    assign bus.passed  = passed_q;
    assign bus.score   = score_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed scoreboard bench for pipe_scroller: one instance at SPEED=2 for
// scrolling, respawn, collision and restart; one at SPEED=40 for saturation.
module tb_pipe_scroller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_scroller_if bus_a ();
    pipe_scroller_if bus_b ();

    pipe_scroller #(.SPEED(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pipe_scroller #(.SPEED(40)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        int x;
        int score;
        int passed;
        int running;
        int respawn;
    } exp_t;

    exp_t sbq[$];
    int   tops[$];

    int vectors    = 0;
    int miscompares = 0;

    // selects which instance is driven and observed
    int sel = 0;

    // reference model state
    int m_state;   // 0 idle, 1 scroll, 2 frozen
    int m_x;
    int m_score;
    int m_top;
    int m_speed = 2;
    int obs_passes = 0;

    function automatic int obs_x();
        return sel ? int'(bus_b.pipe_x) : int'(bus_a.pipe_x);
    endfunction
    function automatic int obs_top();
        return sel ? int'(bus_b.gap_top) : int'(bus_a.gap_top);
    endfunction
    function automatic int obs_bot();
        return sel ? int'(bus_b.gap_bot) : int'(bus_a.gap_bot);
    endfunction
    function automatic int obs_passed();
        return sel ? int'(bus_b.passed) : int'(bus_a.passed);
    endfunction
    function automatic int obs_score();
        return sel ? int'(bus_b.score) : int'(bus_a.score);
    endfunction
    function automatic int obs_running();
        return sel ? int'(bus_b.running) : int'(bus_a.running);
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int passed, input int respawn);
        exp_t e;
        e.x       = m_x;
        e.score   = m_score;
        e.passed  = passed;
        e.running = (m_state == 1) ? 1 : 0;
        e.respawn = respawn;
        sbq.push_back(e);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_x     = 640;
        m_score = 0;
        m_top   = 180;
        push_exp(0, 0);
    endtask

    task automatic model_step(input bit st, input bit tk, input bit co);
        int passed;
        int respawn;
        int nx;
        passed  = 0;
        respawn = 0;
        if (st) begin
            m_state = 1;
            m_x     = 640;
            m_score = 0;
            m_top   = 180;
        end else if (m_state == 1) begin
            if (co) begin
                m_state = 2;
            end else if (tk) begin
                if (m_x >= m_speed) begin
                    nx = m_x - m_speed;
                    if ((m_x + 40 >= 160) && (nx + 40 < 160)) begin
                        passed = 1;
                        if (m_score < 255) m_score = m_score + 1;
                    end
                    m_x = nx;
                end else begin
                    m_x     = 640;
                    respawn = 1;
                end
            end
        end
        push_exp(passed, respawn);
    endtask

    task automatic check_exp(input string tag);
        exp_t e;
        int   ot;
        e  = sbq.pop_front();
        ot = obs_top();
        chk({tag, ".pipe_x"},  obs_x(),       e.x);
        chk({tag, ".score"},   obs_score(),   e.score);
        chk({tag, ".passed"},  obs_passed(),  e.passed);
        chk({tag, ".running"}, obs_running(), e.running);
        chk({tag, ".gap_bot"}, obs_bot(),     ot + 120);
        if (e.respawn != 0) begin
            chk({tag, ".gap_range"}, int'(ot >= 60 && ot <= 187), 1);
            tops.push_back(ot);
            m_top = ot;
        end else begin
            chk({tag, ".gap_top"}, ot, m_top);
        end
        if (obs_passed() == 1) obs_passes++;
    endtask

    task automatic set_inputs(input bit st, input bit tk, input bit co);
        if (sel != 0) begin
            bus_b.start = st; bus_b.tick = tk; bus_b.collide = co;
        end else begin
            bus_a.start = st; bus_a.tick = tk; bus_a.collide = co;
        end
    endtask

    task automatic drive(input bit st, input bit tk, input bit co, input string tag);
        @(negedge clk);
        set_inputs(st, tk, co);
        model_step(st, tk, co);
        @(posedge clk);
        #1;
        set_inputs(1'b0, 1'b0, 1'b0);
        check_exp(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_exp(tag);
    endtask

    initial begin
        int pass_before;
        int distinct;
        int guard;
        reset = 1'b1;
        bus_a.start = 1'b0; bus_a.tick = 1'b0; bus_a.collide = 1'b0;
        bus_b.start = 1'b0; bus_b.tick = 1'b0; bus_b.collide = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("init");

        // 1: reset in the middle of scrolling
        drive(1, 0, 0, "t1_start");
        for (int i = 0; i < 50; i++) drive(0, 1, 0, "t1_tick");
        do_reset("t1_reset");
        chk("t1_reset_x", obs_x(), 640);
        chk("t1_reset_top", obs_top(), 180);
        chk("t1_reset_bot", obs_bot(), 300);
        chk("t1_reset_running", obs_running(), 0);
        drive(0, 1, 0, "t1_idle_tick");
        chk("t1_idle_x", obs_x(), 640);

        // 2: scroll up to the pass point
        drive(1, 0, 0, "t2_start");
        chk("t2_running", obs_running(), 1);
        for (int n = 1; n <= 320; n++) begin
            drive(0, 1, 0, "t2_tick");
            if (n == 260) begin
                chk("t2_x260", obs_x(), 120);
                chk("t2_passed260", obs_passed(), 0);
            end
            if (n == 261) begin
                chk("t2_x261", obs_x(), 118);
                chk("t2_passed261", obs_passed(), 1);
                chk("t2_score261", obs_score(), 1);
                drive(0, 0, 0, "t2_pulse_end");
                chk("t2_pulse_width", obs_passed(), 0);
                pass_before = obs_passes;
            end
        end
        chk("t2_no_extra_pass", obs_passes - pass_before, 0);

        // 3: respawn and 20 further pipes
        chk("t3_x320", obs_x(), 0);
        drive(0, 1, 0, "t3_respawn");
        chk("t3_x321", obs_x(), 640);
        for (int p = 0; p < 20; p++) begin
            for (int n = 0; n < 321; n++) drive(0, 1, 0, "t3_tick");
        end
        distinct = 0;
        foreach (tops[k]) if (tops[k] != tops[0]) distinct = 1;
        chk("t3_respawn_count", tops.size(), 21);
        chk("t3_distinct_gaps", distinct, 1);

        // 4: collision at pipe_x=300 with score 3
        drive(1, 0, 0, "t4_restart");
        guard = 0;
        while (!(m_score == 3 && m_x == 300) && guard < 5000) begin
            drive(0, 1, 0, "t4_tick");
            guard++;
        end
        chk("t4_reach_300", int'(guard < 5000), 1);
        drive(0, 1, 1, "t4_collide");
        chk("t4_x_held", obs_x(), 300);
        chk("t4_running", obs_running(), 0);
        for (int i = 0; i < 10; i++) drive(0, 1, i[0], "t4_frozen");
        chk("t4_x_frozen", obs_x(), 300);
        chk("t4_score_frozen", obs_score(), 3);

        // 5: restart from FROZEN, then start with collide and with tick
        drive(1, 0, 0, "t5_restart");
        chk("t5_score", obs_score(), 0);
        chk("t5_x", obs_x(), 640);
        chk("t5_running", obs_running(), 1);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, "t5_tick");
        drive(1, 0, 1, "t5_start_collide");
        chk("t5_sc_running", obs_running(), 1);
        drive(0, 1, 0, "t5_after_sc");
        chk("t5_after_sc_x", obs_x(), 638);
        drive(1, 1, 0, "t5_start_tick");
        chk("t5_st_x", obs_x(), 640);

        // 6: score saturation on the fast instance
        sel     = 1;
        m_speed = 40;
        do_reset("t6_reset");
        drive(1, 0, 0, "t6_start");
        for (int p = 0; p < 256; p++) begin
            pass_before = obs_passes;
            for (int n = 0; n < 17; n++) drive(0, 1, 0, "t6_tick");
            chk("t6_one_pass_per_pipe", obs_passes - pass_before, 1);
        end
        chk("t6_score_sat", obs_score(), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
